// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_DIGIT_MAX = 9;

    // Smallest output width able to hold 10^ndigits - 1.
    function automatic int min_out_nbits(input int ndigits);
        longint p;
        int     bits;
        p    = 1;
        bits = 0;
        for (int i = 0; i < ndigits; i++) begin
            p = p * 10;
        end
        while ((longint'(1) << bits) < p) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_digit_step.sv
// One Horner step: acc*10 + digit, with non-decimal digits replaced by 0.
module bcd_digit_step
    import bcd2bin_pkg::*;
#(
    parameter int OUT_NBITS = 10
) (
    input  logic [OUT_NBITS-1:0] acc,
    input  logic [3:0]           digit,
    output logic [OUT_NBITS-1:0] acc_next,
    output logic                 digit_err
);

    logic [3:0] digit_legal;

    // Multiply by ten as shift-and-add so no multiplier is inferred.
    always_comb begin
        digit_err   = (digit > 4'(BCD_DIGIT_MAX));
        digit_legal = digit_err ? 4'd0 : digit;
        acc_next    = (acc << 3) + (acc << 1) + OUT_NBITS'(digit_legal);
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per cycle, MS digit first.
//
//   state | meaning
//   IDLE  | ready for a new operand
//   CALC  | folding one digit per cycle into acc
//   DONE  | result presented, waiting for out_rdy
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int NDIGITS   = 3,
    parameter int OUT_NBITS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [4*NDIGITS-1:0]   in_,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [OUT_NBITS-1:0]   out,
    output logic                   out_err
);

    if (NDIGITS < 1 || NDIGITS > 4) begin : g_bad_ndigits
        $error("bcd2bin_seq: NDIGITS must be in 1..4");
    end
    if (OUT_NBITS < min_out_nbits(NDIGITS)) begin : g_bad_width
        $error("bcd2bin_seq: OUT_NBITS too small for NDIGITS");
    end

    localparam logic [1:0] LAST_CNT = 2'(NDIGITS - 1);

    state_t                 state, state_next;
    logic [4*NDIGITS-1:0]   opnd;
    logic [OUT_NBITS-1:0]   acc;
    logic [OUT_NBITS-1:0]   acc_next;
    logic [1:0]             count;
    logic                   err;
    logic                   digit_err;

    bcd_digit_step #(.OUT_NBITS(OUT_NBITS)) u_step (
        .acc       (acc),
        .digit     (opnd[4*NDIGITS-1 -: 4]),
        .acc_next  (acc_next),
        .digit_err (digit_err)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_val)             state_next = CALC;
            CALC:    if (count == LAST_CNT)  state_next = DONE;
            DONE:    if (out_rdy)            state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Datapath: operand shifter, accumulator, digit count and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd  <= '0;
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_val) begin
                    opnd  <= in_;
                    acc   <= '0;
                    count <= '0;
                    err   <= 1'b0;
                end
                CALC: begin
                    acc   <= acc_next;
                    err   <= err | digit_err;
                    opnd  <= opnd << 4;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake and result outputs; forced low while reset is held.
    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        out     = '0;
        out_err = 1'b0;
        if (!reset) begin
            in_rdy  = (state == IDLE);
            out_val = (state == DONE);
            if (state == DONE) begin
                out     = err ? '0 : acc;
                out_err = err;
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: 3-digit and 4-digit instances.
module tb_bcd2bin_seq;

    logic        clk;
    logic        reset;

    logic        in_val, in_rdy, out_val, out_rdy, out_err;
    logic [11:0] in_;
    logic [9:0]  out;

    logic        in_val4, in_rdy4, out_val4, out_rdy4, out_err4;
    logic [15:0] in4;
    logic [13:0] out4;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq #(.NDIGITS(3), .OUT_NBITS(10)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
        .out_val(out_val), .out_rdy(out_rdy), .out(out), .out_err(out_err)
    );

    bcd2bin_seq #(.NDIGITS(4), .OUT_NBITS(14)) dut4 (
        .clk(clk), .reset(reset),
        .in_val(in_val4), .in_rdy(in_rdy4), .in_(in4),
        .out_val(out_val4), .out_rdy(out_rdy4), .out(out4), .out_err(out_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] op;
        int          exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present op to the 3-digit DUT, measure latency, capture the result.
    task automatic run_op(input logic [11:0] op, output int lat,
                          output int res, output logic res_err);
        int n;
        in_    = op;
        in_val = 1'b1;
        n = 0;
        while (!in_rdy && n < 20) begin step(); n++; end
        check("in_rdy_wait", int'(in_rdy), 1);
        step();
        in_val = 1'b0;
        lat = 1;
        while (!out_val && lat < 30) begin step(); lat++; end
        res     = int'(out);
        res_err = out_err;
    endtask

    task automatic run_op4(input logic [15:0] op, input int exp);
        int lat;
        in4     = op;
        in_val4 = 1'b1;
        lat = 0;
        while (!in_rdy4 && lat < 20) begin step(); lat++; end
        step();
        in_val4 = 1'b0;
        lat = 1;
        while (!out_val4 && lat < 30) begin step(); lat++; end
        check("n4_latency", lat, 5);
        check("n4_out", int'(out4), exp);
        check("n4_err", int'(out_err4), 0);
        step();
        check("n4_in_rdy_after", int'(in_rdy4), 1);
    endtask

    initial begin
        int   lat, res;
        logic res_err;
        int   n;

        vecs[0] = '{12'h123, 123, 1'b0};
        vecs[1] = '{12'h000,   0, 1'b0};
        vecs[2] = '{12'h999, 999, 1'b0};
        vecs[3] = '{12'h1A5,   0, 1'b1};
        vecs[4] = '{12'hF00,   0, 1'b1};
        vecs[5] = '{12'h508, 508, 1'b0};
        vecs[6] = '{12'h90B,   0, 1'b1};
        vecs[7] = '{12'h061,  61, 1'b0};

        reset = 1'b1;
        in_val = 1'b0; in_ = '0; out_rdy = 1'b1;
        in_val4 = 1'b0; in4 = '0; out_rdy4 = 1'b1;
        step(); step();
        check("rst_in_rdy", int'(in_rdy), 0);
        check("rst_out_val", int'(out_val), 0);
        check("rst_out", int'(out), 0);
        check("rst_out_err", int'(out_err), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_rdy", int'(in_rdy), 1);

        // Table-driven conversions with out_rdy held high.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, lat, res, res_err);
            check($sformatf("latency_%03h", vecs[i].op), lat, 4);
            check($sformatf("out_%03h", vecs[i].op), res, vecs[i].exp_out);
            check($sformatf("err_%03h", vecs[i].op), int'(res_err), int'(vecs[i].exp_err));
            step();
            check($sformatf("in_rdy_after_%03h", vecs[i].op), int'(in_rdy), 1);
            check($sformatf("out_idle_%03h", vecs[i].op), int'(out), 0);
        end

        // Backpressure: hold out_rdy low for 3 cycles, offer a stray operand.
        out_rdy = 1'b0;
        run_op(12'h042, lat, res, res_err);
        check("bp_latency", lat, 4);
        in_    = 12'h111;
        in_val = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_out", int'(out), 42);
            check("bp_out_val", int'(out_val), 1);
            check("bp_in_rdy", int'(in_rdy), 0);
            if (k == 2) in_val = 1'b0;
            else        step();
        end
        out_rdy = 1'b1;
        step();
        check("bp_release_in_rdy", int'(in_rdy), 1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("bp_no_stray", int'(out_val), 0);
        end

        // Back-to-back with in_val held high.
        in_    = 12'h007;
        in_val = 1'b1;
        n = 0;
        while (!in_rdy && n < 20) begin step(); n++; end
        step();
        in_ = 12'h250;
        lat = 1;
        while (!out_val && lat < 30) begin step(); lat++; end
        check("b2b_lat1", lat, 4);
        check("b2b_out1", int'(out), 7);
        step();
        check("b2b_in_rdy", int'(in_rdy), 1);
        step();
        check("b2b_accepted", int'(in_rdy), 0);
        in_val = 1'b0;
        lat = 1;
        while (!out_val && lat < 30) begin step(); lat++; end
        check("b2b_lat2", lat, 4);
        check("b2b_out2", int'(out), 250);
        step();

        // Reset on the second CALC cycle aborts the operation.
        in_    = 12'h321;
        in_val = 1'b1;
        n = 0;
        while (!in_rdy && n < 20) begin step(); n++; end
        step();
        in_val = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("midrst_in_rdy", int'(in_rdy), 0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_post_in_rdy", int'(in_rdy), 1);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_out", int'(out_val), 0);
            step();
        end
        run_op(12'h005, lat, res, res_err);
        check("midrst_next_lat", lat, 4);
        check("midrst_next_out", res, 5);
        step();

        // Four-digit instance.
        run_op4(16'h9999, 9999);
        run_op4(16'h1234, 1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
